// File: rtl/prog_mem_loadable_if.sv
// Bus bundle for the loadable program memory: CPU fetch port plus byte-wide loader port.
// The master side is the CPU/loader; the slave side is the memory.
interface prog_mem_loadable_if #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4,
  parameter int REG_W  = 3,
  parameter int IMM_W  = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [OP_W-1:0]   data_op;
  logic [REG_W-1:0]  data_rs;
  logic [REG_W-1:0]  data_rt;
  logic [REG_W-1:0]  data_rd;
  logic [IMM_W-1:0]  data_i;

  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_stop;
  logic [7:0]        ld_byte;
  logic              ld_byte_valid;
  logic              ld_ready;
  logic              busy;
  logic              ld_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output fetch_req, fetch_addr, ld_start, ld_base, ld_stop, ld_byte, ld_byte_valid,
    input  fetch_valid, data_op, data_rs, data_rt, data_rd, data_i,
           ld_ready, busy, ld_err, words_loaded
  );

  modport slave (
    input  fetch_req, fetch_addr, ld_start, ld_base, ld_stop, ld_byte, ld_byte_valid,
    output fetch_valid, data_op, data_rs, data_rt, data_rd, data_i,
           ld_ready, busy, ld_err, words_loaded
  );
endinterface

// File: rtl/prog_mem_loadable.sv
// RAM-backed program memory: bytes are assembled MSB-first into words by a loader FSM,
// and the CPU reads decoded instruction fields with a one-cycle fetch latency.
module prog_mem_loadable #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4,
  parameter int REG_W  = 3,
  parameter int IMM_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  prog_mem_loadable_if.slave bus
);

  localparam int WORD_W = OP_W + 3 * REG_W + IMM_W;
  localparam int BPW    = (WORD_W + 7) / 8;
  localparam int ASM_W  = BPW * 8;
  localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RS_LSB = IMM_W + 2 * REG_W;
  localparam int RT_LSB = IMM_W + REG_W;
  localparam int RD_LSB = IMM_W;

  localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ASM_W-1:0]  asm_q, asm_d, asm_shift;
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic              mem_we;

  logic              fetch_valid_q;
  logic [WORD_W-1:0] rdata_q;
  logic              fetch_acc;

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so no latch is inferred; all clocked state below uses non-blocking '<='.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    words_d   = words_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    asm_shift = asm_q << 8;
    asm_shift[7:0] = bus.ld_byte;

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        if (bus.ld_stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (cnt_q != '0) err_d = 1'b1;
        end else if (bus.ld_byte_valid) begin
          asm_d = asm_shift;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        if (words_q != WORDS_MAX) words_d = words_q + 1'b1;
        if (wr_addr_q == {ADDR_W{1'b1}}) err_d = 1'b1;
        state_d = bus.ld_stop ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // A start pulse wins over everything else; a word already in WRITE still commits.
    if (bus.ld_start) begin
      state_d   = S_LOAD;
      wr_addr_d = bus.ld_base;
      cnt_d     = '0;
      words_d   = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      words_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      words_q   <= words_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM and keeps
  // committed words across rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= asm_q[WORD_W-1:0];
  end

  assign fetch_acc = bus.fetch_req && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) rdata_q <= mem[bus.fetch_addr];
    end
  end

  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.data_op      = rdata_q[WORD_W-1 -: OP_W];
  assign bus.data_rs      = rdata_q[RS_LSB +: REG_W];
  assign bus.data_rt      = rdata_q[RT_LSB +: REG_W];
  assign bus.data_rd      = rdata_q[RD_LSB +: REG_W];
  assign bus.data_i       = rdata_q[IMM_W-1:0];
  assign bus.ld_ready     = (state_q == S_LOAD);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.ld_err       = err_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Self-checking bench for prog_mem_loadable: table of instruction words loaded then fetched,
// with a scoreboard queue matching every fetch_valid pulse against the expected word and cycle.
module tb_prog_mem_loadable;
  localparam int ADDR_W = 8;
  localparam int OP_W   = 4;
  localparam int REG_W  = 3;
  localparam int IMM_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_mem_loadable_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .REG_W(REG_W), .IMM_W(IMM_W)) bus ();

  prog_mem_loadable #(.ADDR_W(ADDR_W), .OP_W(OP_W), .REG_W(REG_W), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [7:0] imm;
  } fields_t;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [7:0] addr;
    fields_t    f;
  } vec_t;

  typedef struct {
    int         cyc;
    fields_t    f;
    logic [7:0] addr;
  } exp_t;

  vec_t vec [6];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stalls;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Every fetch_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.fetch_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious fetch_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("fetch[%02h] latency", e.addr), 32'(cyc), 32'(e.cyc));
        check($sformatf("fetch[%02h] fields", e.addr),
              32'({bus.data_op, bus.data_rs, bus.data_rt, bus.data_rd, bus.data_i}), 32'(e.f));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] base);
    bus.ld_base  = base;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic stop();
    bus.ld_stop = 1'b1;
    tick();
    bus.ld_stop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int st);
    bus.ld_byte       = b;
    bus.ld_byte_valid = 1'b1;
    st = 0;
    while (bus.ld_ready !== 1'b1 && st < 20) begin
      st++;
      tick();
    end
    if (st >= 20) check("ld_ready timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_word(input vec_t v, output int st);
    int s0, s1, s2;
    send_byte(v.b0, s0);
    send_byte(v.b1, s1);
    send_byte(v.b2, s2);
    st = s0 + s1 + s2;
  endtask

  task automatic fetch(input logic [7:0] a, input fields_t f);
    bus.fetch_addr = a;
    bus.fetch_req  = 1'b1;
    sb_q.push_back('{cyc + 1, f, a});
    tick();
    bus.fetch_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check({tag, " outstanding fetches"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
    check({tag, " data fields"},
          32'({bus.data_op, bus.data_rs, bus.data_rt, bus.data_rd, bus.data_i}), 32'd0);
    check({tag, " ld_ready"}, 32'(bus.ld_ready), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " ld_err"}, 32'(bus.ld_err), 32'd0);
    check({tag, " words_loaded"}, 32'(bus.words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 21-bit words: op[20:17] rs[16:14] rt[13:11] rd[10:8] imm[7:0]; top 3 pad bits dropped.
    vec[0] = '{8'h1C, 8'h00, 8'h00, 8'h00, '{4'hE, 3'd0, 3'd0, 3'd0, 8'h00}};
    vec[1] = '{8'h04, 8'h01, 8'h00, 8'h01, '{4'h2, 3'd0, 3'd0, 3'd1, 8'h00}};
    vec[2] = '{8'h1F, 8'hFF, 8'hFF, 8'h40, '{4'hF, 3'd7, 3'd7, 3'd7, 8'hFF}};
    vec[3] = '{8'h0A, 8'h5A, 8'h5A, 8'h41, '{4'h5, 3'd1, 3'd3, 3'd2, 8'h5A}};
    vec[4] = '{8'hE0, 8'h00, 8'h01, 8'h42, '{4'h0, 3'd0, 3'd0, 3'd0, 8'h01}};
    vec[5] = '{8'h12, 8'h34, 8'h56, 8'h43, '{4'h9, 3'd0, 3'd6, 3'd4, 8'h56}};

    bus.fetch_req     = 1'b0;
    bus.fetch_addr    = '0;
    bus.ld_start      = 1'b0;
    bus.ld_base       = '0;
    bus.ld_stop       = 1'b0;
    bus.ld_byte       = '0;
    bus.ld_byte_valid = 1'b0;

    repeat (3) tick();
    check_reset_outputs("power-on reset");
    rst_n = 1'b1;
    tick();

    // Two words at base 0x00 from the CPU's original program.
    start(8'h00);
    check("busy after ld_start", 32'(bus.busy), 32'd1);
    check("ld_ready after ld_start", 32'(bus.ld_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      send_word(vec[i], stalls);
      bus.ld_byte_valid = 1'b0;
    end
    stop();
    check("busy after ld_stop", 32'(bus.busy), 32'd0);
    check("ld_ready after ld_stop", 32'(bus.ld_ready), 32'd0);
    check("words_loaded base load", 32'(bus.words_loaded), 32'd2);
    check("ld_err base load", 32'(bus.ld_err), 32'd0);
    for (int i = 0; i < 2; i++) fetch(vec[i].addr, vec[i].f);
    drain("base load");

    // Streamed load with fetch_req held high the whole time.
    start(8'h40);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h00;
    begin
      int total = 0;
      for (int i = 2; i < 6; i++) begin
        send_word(vec[i], stalls);
        total += stalls;
      end
      bus.ld_byte_valid = 1'b0;
      check("ld_ready low cycles over 4 streamed words", 32'(total), 32'd3);
    end
    stop();
    check("busy falls after stop in WRITE", 32'(bus.busy), 32'd0);
    check("words_loaded streamed", 32'(bus.words_loaded), 32'd4);
    check("ld_err streamed", 32'(bus.ld_err), 32'd0);
    for (int i = 5; i >= 0; i--) fetch(vec[i].addr, vec[i].f);
    drain("table fetch");

    // Partial word then stop; a byte offered alongside ld_stop must be refused.
    start(8'h41);
    send_byte(vec[2].b0, stalls);
    send_byte(vec[2].b1, stalls);
    bus.ld_byte = vec[2].b2;
    stop();
    bus.ld_byte_valid = 1'b0;
    check("busy after partial stop", 32'(bus.busy), 32'd0);
    check("ld_err partial word", 32'(bus.ld_err), 32'd1);
    check("words_loaded partial word", 32'(bus.words_loaded), 32'd0);
    fetch(8'h41, vec[3].f);
    drain("partial word");

    // Address wrap from 0xFF to 0x00.
    start(8'hFF);
    check("ld_err cleared by ld_start", 32'(bus.ld_err), 32'd0);
    send_word(vec[3], stalls);
    send_word(vec[4], stalls);
    bus.ld_byte_valid = 1'b0;
    stop();
    check("ld_err wrap", 32'(bus.ld_err), 32'd1);
    check("words_loaded wrap", 32'(bus.words_loaded), 32'd2);
    fetch(8'hFF, vec[3].f);
    fetch(8'h00, vec[4].f);
    drain("wrap");

    // ld_start mid-word restarts at the new base with the partial word discarded.
    start(8'h80);
    send_byte(vec[5].b0, stalls);
    bus.ld_byte = vec[5].b1;
    start(8'h90);
    check("ld_err after restart", 32'(bus.ld_err), 32'd0);
    check("words_loaded after restart", 32'(bus.words_loaded), 32'd0);
    send_word(vec[2], stalls);
    send_word(vec[5], stalls);
    bus.ld_byte_valid = 1'b0;
    stop();
    check("words_loaded restart", 32'(bus.words_loaded), 32'd2);
    check("ld_err restart", 32'(bus.ld_err), 32'd0);
    fetch(8'h90, vec[2].f);
    fetch(8'h91, vec[5].f);
    drain("restart");

    // Asynchronous reset in the middle of a load.
    start(8'hA0);
    send_word(vec[0], stalls);
    send_byte(vec[1].b0, stalls);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-load reset");
    bus.ld_byte_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("busy after reset release", 32'(bus.busy), 32'd0);
    check("ld_ready after reset release", 32'(bus.ld_ready), 32'd0);
    fetch(8'hA0, vec[0].f);
    fetch(8'h91, vec[5].f);
    drain("after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
